// File: rtl/adc_strobe_gen.sv
// adc_strobe_gen: per-channel programmable one-cycle ADC sample strobes with burst mode, sample counters and done flags.
// Optional ADC_STROBE_SYNC_EN adds an ARMED state and sync-pulse phase alignment.  Rev 1.0
`default_nettype none

module adc_strobe_gen #(
   parameter int CHANNELS  = 4,
   parameter int DIV_WIDTH = 16,
   parameter int CNT_WIDTH = 16
) (
   input  logic                          wb_clk,
   input  logic                          wb_rst_n,
   input  logic [CHANNELS-1:0]           ch_enable,
   input  logic [CHANNELS-1:0]           ch_burst_mode,
   input  logic [CHANNELS*DIV_WIDTH-1:0] ch_divider,
   input  logic [CHANNELS*CNT_WIDTH-1:0] ch_burst_len,
   input  logic                          sync,
   output logic [CHANNELS-1:0]           sample_strobe,
   output logic [CHANNELS-1:0]           ch_busy,
   output logic [CHANNELS-1:0]           ch_done,
   output logic [CHANNELS*CNT_WIDTH-1:0] ch_sample_count
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DONE  = 2'd2,
      ST_ARMED = 2'd3
   } ch_state_t;

`ifdef ADC_STROBE_SYNC_EN
   logic sync_hit;
   assign sync_hit = sync;
`else
   logic unused_sync;
   assign unused_sync = sync;
`endif

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      ch_state_t            state, state_nxt;
      logic [DIV_WIDTH-1:0] div_cnt, div_cnt_nxt;
      logic [CNT_WIDTH-1:0] count, count_nxt, count_inc;
      logic                 strobe, strobe_nxt;
      logic [DIV_WIDTH-1:0] divider;
      logic [CNT_WIDTH-1:0] burst_len;

      assign divider   = ch_divider[i*DIV_WIDTH +: DIV_WIDTH];
      assign burst_len = ch_burst_len[i*CNT_WIDTH +: CNT_WIDTH];
      assign count_inc = count + CNT_WIDTH'(1);

      always_ff @(posedge wb_clk or negedge wb_rst_n) begin
         if (!wb_rst_n) begin
            state   <= ST_IDLE;
            div_cnt <= '0;
            count   <= '0;
            strobe  <= 1'b0;
         end else begin
            state   <= state_nxt;
            div_cnt <= div_cnt_nxt;
            count   <= count_nxt;
            strobe  <= strobe_nxt;
         end
      end

      always_comb begin
         state_nxt   = state;
         div_cnt_nxt = div_cnt;
         count_nxt   = count;
         strobe_nxt  = 1'b0;
         // Dropping enable wins over everything, including a strobe due this edge.
         if (!ch_enable[i]) begin
            state_nxt = ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  count_nxt   = '0;
                  div_cnt_nxt = divider;
                  if (ch_burst_mode[i] && (burst_len == '0)) begin
                     state_nxt = ST_DONE;
                  end else begin
`ifdef ADC_STROBE_SYNC_EN
                     state_nxt = ST_ARMED;
`else
                     state_nxt = ST_RUN;
`endif
                  end
               end
`ifdef ADC_STROBE_SYNC_EN
               ST_ARMED: begin
                  if (sync_hit) begin
                     state_nxt   = ST_RUN;
                     div_cnt_nxt = divider;
                  end
               end
`endif
               ST_RUN: begin
`ifdef ADC_STROBE_SYNC_EN
                  if (sync_hit) begin
                     div_cnt_nxt = divider;
                  end else
`endif
                  if (div_cnt != '0) begin
                     div_cnt_nxt = div_cnt - DIV_WIDTH'(1);
                  end else begin
                     strobe_nxt  = 1'b1;
                     div_cnt_nxt = divider;
                     count_nxt   = count_inc;
                     if (ch_burst_mode[i] && (count_inc == burst_len)) begin
                        state_nxt = ST_DONE;
                     end
                  end
               end
               ST_DONE: begin
                  state_nxt = ST_DONE;
               end
               default: begin
                  state_nxt = ST_IDLE;
               end
            endcase
         end
      end

      assign sample_strobe[i]                           = strobe;
      assign ch_busy[i]                                 = (state == ST_RUN);
      assign ch_done[i]                                 = (state == ST_DONE);
      assign ch_sample_count[i*CNT_WIDTH +: CNT_WIDTH]  = count;
   end

endmodule

`default_nettype wire

// File: tb/tb_adc_strobe_gen.sv
// tb_adc_strobe_gen: randomized and directed checks of adc_strobe_gen against a timestamp-based reference model.
`default_nettype none

module tb_adc_strobe_gen;

   localparam int CH = 4;
   localparam int DW = 8;
   localparam int CW = 4;
`ifdef ADC_STROBE_SYNC_EN
   localparam bit SYNC_EN = 1'b1;
`else
   localparam bit SYNC_EN = 1'b0;
`endif

   localparam int P_IDLE  = 0;
   localparam int P_RUN   = 1;
   localparam int P_DONE  = 2;
   localparam int P_ARMED = 3;

   logic               wb_clk = 1'b0;
   logic               wb_rst_n = 1'b0;
   logic [CH-1:0]      ch_enable = '0;
   logic [CH-1:0]      ch_burst_mode = '0;
   logic [CH*DW-1:0]   ch_divider = '0;
   logic [CH*CW-1:0]   ch_burst_len = '0;
   logic               sync = 1'b0;
   logic [CH-1:0]      sample_strobe;
   logic [CH-1:0]      ch_busy;
   logic [CH-1:0]      ch_done;
   logic [CH*CW-1:0]   ch_sample_count;

   adc_strobe_gen #(.CHANNELS(CH), .DIV_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .wb_clk          (wb_clk),
      .wb_rst_n        (wb_rst_n),
      .ch_enable       (ch_enable),
      .ch_burst_mode   (ch_burst_mode),
      .ch_divider      (ch_divider),
      .ch_burst_len    (ch_burst_len),
      .sync            (sync),
      .sample_strobe   (sample_strobe),
      .ch_busy         (ch_busy),
      .ch_done         (ch_done),
      .ch_sample_count (ch_sample_count)
   );

   always #5 wb_clk = ~wb_clk;

   int total = 0;
   int bad   = 0;

   // Model: each running channel remembers the absolute edge number of its next strobe.
   int            edge_no = 0;
   int            m_phase [CH];
   int            m_next  [CH];
   int            m_cnt   [CH];
   logic [CH-1:0] m_strobe;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic int div_of(input int i);
      return int'(ch_divider[i*DW +: DW]);
   endfunction

   function automatic int len_of(input int i);
      return int'(ch_burst_len[i*CW +: CW]);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < CH; i++) begin
         m_phase[i] = P_IDLE;
         m_next[i]  = 0;
         m_cnt[i]   = 0;
      end
      m_strobe = '0;
   endtask

   task automatic model_edge();
      edge_no++;
      m_strobe = '0;
      if (!wb_rst_n) begin
         model_reset();
         return;
      end
      for (int i = 0; i < CH; i++) begin
         if (!ch_enable[i]) begin
            m_phase[i] = P_IDLE;
         end else if (m_phase[i] == P_IDLE) begin
            m_cnt[i] = 0;
            if (ch_burst_mode[i] && len_of(i) == 0) m_phase[i] = P_DONE;
            else if (SYNC_EN) m_phase[i] = P_ARMED;
            else begin
               m_phase[i] = P_RUN;
               m_next[i]  = edge_no + div_of(i) + 1;
            end
         end else if (m_phase[i] == P_ARMED) begin
            if (sync) begin
               m_phase[i] = P_RUN;
               m_next[i]  = edge_no + div_of(i) + 1;
            end
         end else if (m_phase[i] == P_RUN) begin
            if (SYNC_EN && sync) begin
               m_next[i] = edge_no + div_of(i) + 1;
            end else if (edge_no == m_next[i]) begin
               m_strobe[i] = 1'b1;
               m_cnt[i]    = (m_cnt[i] + 1) % (1 << CW);
               m_next[i]   = edge_no + div_of(i) + 1;
               if (ch_burst_mode[i] && m_cnt[i] == len_of(i)) m_phase[i] = P_DONE;
            end
         end
      end
   endtask

   task automatic compare_all();
      logic [CH-1:0]    e_busy;
      logic [CH-1:0]    e_done;
      logic [CH*CW-1:0] e_cnt;
      for (int i = 0; i < CH; i++) begin
         e_busy[i]          = (m_phase[i] == P_RUN);
         e_done[i]          = (m_phase[i] == P_DONE);
         e_cnt[i*CW +: CW]  = CW'(m_cnt[i]);
      end
      check("strobe", 64'(sample_strobe), 64'(m_strobe));
      check("busy",   64'(ch_busy),       64'(e_busy));
      check("done",   64'(ch_done),       64'(e_done));
      check("count",  64'(ch_sample_count), 64'(e_cnt));
   endtask

   task automatic tick();
      @(posedge wb_clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic set_div(input int i, input int d);
      ch_divider[i*DW +: DW] = DW'(d);
   endtask

   initial begin
      model_reset();
      repeat (3) tick();
      check("rst_outputs", 64'({sample_strobe, ch_busy, ch_done, ch_sample_count}), 64'(0));
      wb_rst_n = 1'b1;

`ifndef ADC_STROBE_SYNC_EN
      // Continuous, divider 3: strobes at enable edge +4, +8, +12.
      set_div(0, 3);
      ch_enable[0] = 1'b1;
      repeat (13) tick();
      check("cont_cnt3", 64'(ch_sample_count[CW-1:0]), 64'(3));
      check("cont_strobe", 64'(sample_strobe[0]), 64'(1));
      set_div(0, 0);
      repeat (10) tick();

      // Asynchronous reset between edges.
      #2 wb_rst_n = 1'b0;
      #1;
      check("arst_zero", 64'({sample_strobe, ch_busy, ch_done, ch_sample_count}), 64'(0));
      #2 wb_rst_n = 1'b1;
      model_reset();
      repeat (2) tick();
      check("arst_restart_cnt", 64'(ch_sample_count[CW-1:0]), 64'(1));
      ch_enable[0] = 1'b0;
      tick();

      // Burst of 5 on ch1, divider 1.
      set_div(1, 1);
      ch_burst_mode[1] = 1'b1;
      ch_burst_len[1*CW +: CW] = CW'(5);
      ch_enable[1] = 1'b1;
      repeat (11) tick();
      check("burst_done", 64'(ch_done[1]), 64'(1));
      check("burst_last_strobe", 64'(sample_strobe[1]), 64'(1));
      check("burst_cnt", 64'(ch_sample_count[1*CW +: CW]), 64'(5));
      repeat (4) tick();
      check("burst_hold", 64'(ch_sample_count[1*CW +: CW]), 64'(5));
      ch_enable[1] = 1'b0;
      tick();
      check("burst_done_clr", 64'(ch_done[1]), 64'(0));

      // Burst length zero: straight to DONE, no strobe.
      ch_burst_len[1*CW +: CW] = '0;
      ch_enable[1] = 1'b1;
      tick();
      check("len0_done", 64'({ch_done[1], ch_busy[1], sample_strobe[1]}), 64'(3'b100));
      repeat (3) tick();
      ch_enable[1] = 1'b0;
      tick();

      // Enable dropped on the edge where the strobe would be issued.
      set_div(2, 2);
      ch_enable[2] = 1'b1;
      repeat (3) tick();
      ch_enable[2] = 1'b0;
      tick();
      check("drop_no_strobe", 64'(sample_strobe[2]), 64'(0));

      // Counter wrap with divider 0.
      set_div(3, 0);
      ch_enable[3] = 1'b1;
      repeat (17) tick();
      check("wrap_cnt", 64'(ch_sample_count[3*CW +: CW]), 64'(0));
      check("wrap_strobe", 64'(sample_strobe[3]), 64'(1));
      ch_enable[3] = 1'b0;
      tick();

      // Independence and mid-period divider change.
      set_div(0, 2);
      set_div(3, 6);
      ch_enable[0] = 1'b1;
      ch_enable[3] = 1'b1;
      repeat (5) tick();
      set_div(0, 5);
      repeat (20) tick();
      ch_enable = '0;
      tick();
`else
      // Sync alignment of ch0 and ch2, both divider 4.
      set_div(0, 4);
      set_div(2, 4);
      ch_enable[0] = 1'b1;
      repeat (3) tick();
      ch_enable[2] = 1'b1;
      repeat (3) tick();
      sync = 1'b1;
      tick();
      sync = 1'b0;
      repeat (5) tick();
      check("sync_align", 64'({sample_strobe[2], sample_strobe[0]}), 64'(2'b11));
      repeat (2) tick();
      sync = 1'b1;
      tick();
      sync = 1'b0;
      check("sync_no_strobe", 64'({sample_strobe[2], sample_strobe[0]}), 64'(0));
      repeat (5) tick();
      check("sync_realign", 64'({sample_strobe[2], sample_strobe[0]}), 64'(2'b11));
      ch_enable = '0;
      tick();
`endif

      // Randomized operation of all channels.
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < CH; i++) begin
            if ($urandom_range(0, 24) == 0) ch_enable[i] = ~ch_enable[i];
            if ($urandom_range(0, 29) == 0) set_div(i, int'($urandom_range(0, 5)));
            if (!ch_enable[i] && $urandom_range(0, 3) == 0) begin
               ch_burst_mode[i] = 1'($urandom_range(0, 1));
               ch_burst_len[i*CW +: CW] = CW'($urandom_range(0, 7));
            end
         end
         sync = ($urandom_range(0, 15) == 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
